fetch: RTL and testbench

Instruction fetch unit: holds the program counter, issues one word-aligned read at a time to instruction memory over a request/grant/response handshake, and presents each returned instruction word with its PC to the decoder (which embeds the immediate generator) over a valid/ready handshake. Control-flow redirects (taken branches, JAL/JALR targets) from execute squash wrong-path fetches and restart fetch at the new PC.

---
 rtl/fetch_if.sv | 39 +++
 rtl/fetch.sv | 138 +++++++++++++
 tb/tb_fetch.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : fetch_if                                                   |
// | Description : Instruction-memory request/grant/response bus, redirect    |
// |               input and fetch-to-decode valid/ready channel, bundled for |
// |               the fetch unit.                                            |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
interface fetch_if;
   // instruction memory side
   logic        o_imem_req;
   logic [31:0] o_imem_addr;
   logic        i_imem_gnt;
   logic        i_imem_rvalid;
   logic [31:0] i_imem_rdata;
   // control-flow redirect from execute
   logic        i_redirect;
   logic [31:0] i_redirect_pc;
   // decoder side
   logic        o_inst_valid;
   logic [31:0] o_inst;
   logic [31:0] o_inst_pc;
   logic        i_inst_ready;

   // fetch unit view
   modport master (
      output o_imem_req, o_imem_addr, o_inst_valid, o_inst, o_inst_pc,
      input  i_imem_gnt, i_imem_rvalid, i_imem_rdata,
      input  i_redirect, i_redirect_pc, i_inst_ready
   );

   // memory / execute / decoder view
   modport slave (
      input  o_imem_req, o_imem_addr, o_inst_valid, o_inst, o_inst_pc,
      output i_imem_gnt, i_imem_rvalid, i_imem_rdata,
      output i_redirect, i_redirect_pc, i_inst_ready
   );
endinterface
`default_nettype wire

// File: rtl/fetch.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : fetch                                                      |
// | Description : Instruction fetch unit. Keeps the PC, issues one aligned   |
// |               read at a time, presents fetched words to decode and       |
// |               squashes wrong-path fetches on redirect.                   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module fetch #(
   parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
   input  wire logic i_clk,
   input  wire logic i_rst,
   fetch_if.master   bus
);

   localparam logic [31:0] C_NOP = 32'h0000_0013;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] req_pc_q, req_pc_d;
   logic        drop_q, drop_d;
   logic        imem_req_q, imem_req_d;
   logic [31:0] imem_addr_q, imem_addr_d;
   logic        inst_valid_q, inst_valid_d;
   logic [31:0] inst_q, inst_d;
   logic [31:0] inst_pc_q, inst_pc_d;

   logic [31:0] redirect_target;
   logic        xfer;
   logic        unused_redirect_lsbs;

   // The two low target bits are discarded: every fetch is word aligned.
   assign unused_redirect_lsbs = ^bus.i_redirect_pc[1:0];
   assign redirect_target      = {bus.i_redirect_pc[31:2], 2'b00};
   assign xfer                 = inst_valid_q && bus.i_inst_ready;

   // Next-state logic: request sequencing, response capture and redirect squash.
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      req_pc_d     = req_pc_q;
      drop_d       = drop_q;
      inst_valid_d = inst_valid_q;
      inst_d       = inst_q;
      inst_pc_d    = inst_pc_q;

      // a consumed word leaves the output register empty unless refilled below
      if (xfer) begin
         inst_valid_d = 1'b0;
      end

      case (state_q)
         ST_IDLE: begin
            // only ask for a new word when there will be room to hold it
            if (!inst_valid_q || xfer || bus.i_redirect) begin
               state_d = ST_REQ;
            end
         end
         ST_REQ: begin
            if (bus.i_imem_gnt) begin
               req_pc_d = pc_q;
               pc_d     = pc_q + 32'd4;
               // a request granted alongside a redirect is already wrong-path
               drop_d   = bus.i_redirect;
               state_d  = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (bus.i_imem_rvalid) begin
               if (drop_q || bus.i_redirect) begin
                  drop_d  = 1'b0;
                  state_d = ST_REQ;
               end else begin
                  inst_d       = bus.i_imem_rdata;
                  inst_pc_d    = req_pc_q;
                  inst_valid_d = 1'b1;
                  state_d      = ST_IDLE;
               end
            end else if (bus.i_redirect) begin
               // the in-flight response must still be absorbed, then discarded
               drop_d = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // redirect wins over the sequential increment and kills the held word
      if (bus.i_redirect) begin
         pc_d         = redirect_target;
         inst_valid_d = 1'b0;
      end

      imem_req_d  = (state_d == ST_REQ);
      imem_addr_d = pc_d;
   end

   // State and output registers; reset returns everything to the boot PC.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q      <= ST_IDLE;
         pc_q         <= RESET_ADDR;
         req_pc_q     <= RESET_ADDR;
         drop_q       <= 1'b0;
         imem_req_q   <= 1'b0;
         imem_addr_q  <= RESET_ADDR;
         inst_valid_q <= 1'b0;
         inst_q       <= C_NOP;
         inst_pc_q    <= RESET_ADDR;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         req_pc_q     <= req_pc_d;
         drop_q       <= drop_d;
         imem_req_q   <= imem_req_d;
         imem_addr_q  <= imem_addr_d;
         inst_valid_q <= inst_valid_d;
         inst_q       <= inst_d;
         inst_pc_q    <= inst_pc_d;
      end
   end

   assign bus.o_imem_req   = imem_req_q;
   assign bus.o_imem_addr  = imem_addr_q;
   assign bus.o_inst_valid = inst_valid_q;
   assign bus.o_inst       = inst_q;
   assign bus.o_inst_pc    = inst_pc_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_fetch                                                   |
// | Description : Self-checking bench for fetch: directed protocol scenarios |
// |               followed by randomized traffic against a program-order     |
// |               reference model.                                           |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_fetch;

   localparam logic [31:0] C_BOOT0 = 32'h0000_0000;
   localparam logic [31:0] C_BOOT1 = 32'hFFFF_FFFC;

   logic clk;
   logic rst;

   fetch_if bus0 ();
   fetch_if bus1 ();

   fetch #(.RESET_ADDR(C_BOOT0)) dut0 (.i_clk(clk), .i_rst(rst), .bus(bus0));
   fetch #(.RESET_ADDR(C_BOOT1)) dut1 (.i_clk(clk), .i_rst(rst), .bus(bus1));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          n_vec = 0;
   int          n_err = 0;
   int          n_deliv = 0;

   // reference model: next instruction address expected in program order
   logic [31:0] exp_pc;
   logic [31:0] exp_pc1;

   // memory responder state (one outstanding read per DUT)
   logic        pend, pend1;
   logic [31:0] pend_addr, pend1_addr;
   int          pend_cnt;
   int          gnt_stall;
   int          rv_delay;
   bit          rand_mode;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'hA5A5_0000;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_vec++;
      assert (obs === exp_v) else begin
         n_err++;
         $error("FAIL %s: observed %h, expected %h", tag, obs, exp_v);
      end
   endtask

   // One clock cycle: memory responds, transfers are checked against the
   // program-order model, then the edge is taken and outputs sampled at +1.
   task automatic tick();
      logic        req_b, gnt_b, rv_b, redir_b, req1_b, gnt1_b, rv1_b;
      logic [31:0] addr_b, addr1_b;
      req_b   = bus0.o_imem_req;
      addr_b  = bus0.o_imem_addr;
      gnt_b   = 1'b0;
      if (req_b) begin
         if (rand_mode)          gnt_b = ($urandom_range(0, 2) != 0);
         else if (gnt_stall > 0) gnt_stall--;
         else                    gnt_b = 1'b1;
      end
      rv_b = pend && (pend_cnt == 0);
      bus0.i_imem_gnt    = gnt_b;
      bus0.i_imem_rvalid = rv_b;
      bus0.i_imem_rdata  = rv_b ? mem_word(pend_addr) : $urandom();

      req1_b  = bus1.o_imem_req;
      addr1_b = bus1.o_imem_addr;
      gnt1_b  = req1_b;
      rv1_b   = pend1;
      bus1.i_imem_gnt    = gnt1_b;
      bus1.i_imem_rvalid = rv1_b;
      bus1.i_imem_rdata  = mem_word(pend1_addr);

      redir_b = bus0.i_redirect;
      if (bus0.o_inst_valid && bus0.i_inst_ready && !redir_b) begin
         chk("inst_pc", bus0.o_inst_pc, exp_pc);
         chk("inst_word", bus0.o_inst, mem_word(exp_pc));
         exp_pc = exp_pc + 32'd4;
         n_deliv++;
      end
      if (redir_b) exp_pc = bus0.i_redirect_pc & 32'hFFFF_FFFC;

      if (bus1.o_inst_valid) begin
         chk("wrap_inst_pc", bus1.o_inst_pc, exp_pc1);
         chk("wrap_inst_word", bus1.o_inst, mem_word(exp_pc1));
         exp_pc1 = exp_pc1 + 32'd4;
      end

      @(posedge clk);
      #1;

      if (rv_b) pend = 1'b0;
      else if (pend && pend_cnt > 0) pend_cnt--;
      if (gnt_b) begin
         chk("one_outstanding", 32'(pend), 32'd0);
         pend      = 1'b1;
         pend_addr = addr_b;
         pend_cnt  = rand_mode ? int'($urandom_range(0, 3)) : rv_delay;
      end
      if (req_b && !gnt_b && !redir_b) begin
         chk("req_hold", 32'(bus0.o_imem_req), 32'd1);
         chk("addr_hold", bus0.o_imem_addr, addr_b);
      end

      if (rv1_b) pend1 = 1'b0;
      if (gnt1_b) begin
         pend1      = 1'b1;
         pend1_addr = addr1_b;
      end
   endtask

   task automatic wait_valid(input string tag);
      int n = 0;
      while (!bus0.o_inst_valid && n < 40) begin
         tick();
         n++;
      end
      chk(tag, 32'(bus0.o_inst_valid), 32'd1);
   endtask

   task automatic wait_req_at(input string tag, input logic [31:0] a);
      int n = 0;
      while (!(bus0.o_imem_req && bus0.o_imem_addr == a) && n < 60) begin
         tick();
         n++;
      end
      chk(tag, bus0.o_imem_addr, a);
   endtask

   task automatic pulse_redirect(input logic [31:0] target);
      bus0.i_redirect    = 1'b1;
      bus0.i_redirect_pc = target;
      tick();
      bus0.i_redirect    = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      bus0.i_imem_gnt = 1'b0; bus0.i_imem_rvalid = 1'b0; bus0.i_imem_rdata = 32'd0;
      bus0.i_redirect = 1'b0; bus0.i_redirect_pc = 32'd0; bus0.i_inst_ready = 1'b1;
      bus1.i_imem_gnt = 1'b0; bus1.i_imem_rvalid = 1'b0; bus1.i_imem_rdata = 32'd0;
      bus1.i_redirect = 1'b0; bus1.i_redirect_pc = 32'd0; bus1.i_inst_ready = 1'b1;
      pend = 1'b0; pend1 = 1'b0; pend_addr = 32'd0; pend1_addr = 32'd0;
      pend_cnt = 0; gnt_stall = 0; rv_delay = 0; rand_mode = 1'b0;
      exp_pc = C_BOOT0; exp_pc1 = C_BOOT1;

      // reset values
      repeat (2) @(posedge clk);
      #1;
      chk("rst_req", 32'(bus0.o_imem_req), 32'd0);
      chk("rst_addr", bus0.o_imem_addr, C_BOOT0);
      chk("rst_valid", 32'(bus0.o_inst_valid), 32'd0);
      chk("rst_inst", bus0.o_inst, 32'h0000_0013);
      chk("rst_inst_pc", bus0.o_inst_pc, C_BOOT0);
      chk("rst_addr_hi", bus1.o_imem_addr, C_BOOT1);
      rst = 1'b0;

      // zero-wait memory, ready high: request every third cycle
      for (int k = 1; k <= 6; k++) begin
         tick();
         chk("zw_req_period", 32'(bus0.o_imem_req), 32'((k % 3) == 1));
         chk("zw_valid_period", 32'(bus0.o_inst_valid), 32'((k % 3) == 0));
         if (k == 1) chk("wrap_first_addr", bus1.o_imem_addr, 32'hFFFF_FFFC);
         if (k == 4) chk("wrap_second_addr", bus1.o_imem_addr, 32'h0000_0000);
      end
      chk("wrap_second_pc", bus1.o_inst_pc, 32'h0000_0000);

      // grant withheld four cycles on the request for 0x8
      gnt_stall = 4;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("stall_req", 32'(bus0.o_imem_req), 32'd1);
         chk("stall_addr", bus0.o_imem_addr, 32'h0000_0008);
      end

      // decoder back-pressure holds the output and blocks new requests
      wait_valid("bp_valid_wait");
      bus0.i_inst_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("bp_valid", 32'(bus0.o_inst_valid), 32'd1);
         chk("bp_inst_pc", bus0.o_inst_pc, exp_pc);
         chk("bp_inst", bus0.o_inst, mem_word(exp_pc));
         chk("bp_no_req", 32'(bus0.o_imem_req), 32'd0);
      end
      bus0.i_inst_ready = 1'b1;
      tick();
      chk("bp_release_req", 32'(bus0.o_imem_req), 32'd1);
      chk("bp_release_addr", bus0.o_imem_addr, exp_pc);

      // redirect while waiting on 0x20, response two cycles later
      wait_req_at("reach_0x20", 32'h0000_0020);
      rv_delay = 2;
      tick();
      rv_delay = 0;
      pulse_redirect(32'h0000_1003);
      chk("wait_redir_valid", 32'(bus0.o_inst_valid), 32'd0);
      chk("wait_redir_req", 32'(bus0.o_imem_req), 32'd0);
      tick();
      chk("wait_drop_valid", 32'(bus0.o_inst_valid), 32'd0);
      chk("wait_drop_req", 32'(bus0.o_imem_req), 32'd0);
      tick();
      chk("after_drop_req", 32'(bus0.o_imem_req), 32'd1);
      chk("after_drop_addr", bus0.o_imem_addr, 32'h0000_1000);
      chk("after_drop_valid", 32'(bus0.o_inst_valid), 32'd0);
      wait_valid("redir_valid_wait");
      chk("redir_inst_pc", bus0.o_inst_pc, 32'h0000_1000);

      // redirect coinciding with grant of 0x40, then with an rvalid
      pulse_redirect(32'h0000_0038);
      wait_req_at("reach_0x40", 32'h0000_0040);
      pulse_redirect(32'h0000_2000);
      chk("gnt_redir_req", 32'(bus0.o_imem_req), 32'd0);
      tick();
      chk("gnt_drop_req", 32'(bus0.o_imem_req), 32'd1);
      chk("gnt_drop_addr", bus0.o_imem_addr, 32'h0000_2000);
      chk("gnt_drop_valid", 32'(bus0.o_inst_valid), 32'd0);
      tick();
      chk("rv_redir_wait", 32'(bus0.o_imem_req), 32'd0);
      pulse_redirect(32'h0000_3000);
      chk("rv_redir_req", 32'(bus0.o_imem_req), 32'd1);
      chk("rv_redir_addr", bus0.o_imem_addr, 32'h0000_3000);
      chk("rv_redir_valid", 32'(bus0.o_inst_valid), 32'd0);
      wait_valid("rv_redir_valid_wait");
      chk("rv_redir_inst_pc", bus0.o_inst_pc, 32'h0000_3000);
      chk("rv_redir_inst", bus0.o_inst, mem_word(32'h0000_3000));

      // asynchronous reset in WAIT; the stale response lands in IDLE
      wait_req_at("reach_0x3008", 32'h0000_3008);
      tick();
      pend_cnt = 3;
      rst = 1'b1;
      #1;
      chk("arst_req", 32'(bus0.o_imem_req), 32'd0);
      chk("arst_addr", bus0.o_imem_addr, C_BOOT0);
      chk("arst_valid", 32'(bus0.o_inst_valid), 32'd0);
      chk("arst_inst", bus0.o_inst, 32'h0000_0013);
      @(posedge clk);
      #1;
      rst = 1'b0;
      exp_pc = C_BOOT0; exp_pc1 = C_BOOT1; pend1 = 1'b0; pend_cnt = 0;
      tick();
      chk("arst_stale_req", 32'(bus0.o_imem_req), 32'd1);
      chk("arst_stale_addr", bus0.o_imem_addr, C_BOOT0);
      chk("arst_stale_valid", 32'(bus0.o_inst_valid), 32'd0);
      wait_valid("arst_valid_wait");
      chk("arst_inst_pc", bus0.o_inst_pc, C_BOOT0);

      // randomized grants, latencies, back-pressure and redirects
      rand_mode = 1'b1;
      n_deliv = 0;
      for (int i = 0; i < 800; i++) begin
         bus0.i_inst_ready  = ($urandom_range(0, 3) != 0);
         bus0.i_redirect    = ($urandom_range(0, 24) == 0);
         bus0.i_redirect_pc = $urandom();
         tick();
      end
      bus0.i_redirect = 1'b0;
      chk("random_progress", 32'(n_deliv > 40), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
